// File: rtl/sixbit_equal_sequencer.sv
// rtl/sixbit_equal_sequencer.sv - sweeps all 4096 operand pairs of a six-bit equality comparator and checks its equal output
module sixbit_equal_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [5:0]  a_out,
    output logic [5:0]  b_out,
    input  logic        equal_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [12:0] err_count,
    output logic        fail_seen,
    output logic [11:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [11:0] IDX_LAST    = 12'hFFF;

    state_t      state_q;
    logic [11:0] idx_q;
    logic [7:0]  settle_cnt_q;
    logic [12:0] err_count_q;
    logic        fail_seen_q;
    logic [11:0] first_fail_idx_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic        mismatch;
    logic [12:0] err_count_d;
    logic [11:0] idx_d;

    // The operands are the two halves of the registered vector index.
    assign mismatch    = equal_in != (idx_q[11:6] == idx_q[5:0]);
    assign err_count_d = mismatch ? err_count_q + 13'd1 : err_count_q;
    assign idx_d       = idx_q + 12'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            settle_cnt_q     <= '0;
            err_count_q      <= '0;
            fail_seen_q      <= 1'b0;
            first_fail_idx_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else if (abort) begin
            // Partial results stay visible; the vector in flight is dropped.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q          <= SETTLE;
                        idx_q            <= '0;
                        settle_cnt_q     <= '0;
                        err_count_q      <= '0;
                        fail_seen_q      <= 1'b0;
                        first_fail_idx_q <= '0;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                    end
                end
                SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 8'd1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_count_q <= err_count_d;
                    if (mismatch && !fail_seen_q) begin
                        fail_seen_q      <= 1'b1;
                        first_fail_idx_q <= idx_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 13'd0);
                    end else begin
                        state_q      <= SETTLE;
                        idx_q        <= idx_d;
                        settle_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out          = idx_q[11:6];
    assign b_out          = idx_q[5:0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_idx = first_fail_idx_q;

endmodule
